// File: rtl/exe_stage_if.sv
// Port bundle of the execute stage: ID->EXE handshake, EXE->MEM handshake,
// data SRAM request and the forwarding bus back to ID.
interface exe_stage_if;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [151:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         out_es_valid;
  logic [38:0]  es_fwd_bus;

  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           out_es_valid, es_fwd_bus
  );

  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           out_es_valid, es_fwd_bus
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus a 32-step restoring divider, data SRAM
// request issue, and the EXE->MEM / EXE->ID (forwarding) buses.
module exe_stage (
  input  logic       clk,
  input  logic       reset,
  exe_stage_if.master io
);

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic         es_valid;
  logic [151:0] es_bus;

  logic [11:0]  alu_op;
  logic [3:0]   div_op;
  logic         res_from_mem;
  logic         mem_we;
  logic         gr_we;
  logic [4:0]   dest;
  logic [31:0]  src1;
  logic [31:0]  src2;
  logic [31:0]  rkd_value;
  logic [31:0]  pc;

  assign {alu_op, div_op, res_from_mem, mem_we, gr_we, dest,
          src1, src2, rkd_value, pc} = es_bus;

  logic        is_div;
  logic        es_ready_go;
  logic        es_allowin;
  logic [1:0]  div_state;
  logic [31:0] alu_result;

  assign is_div      = |div_op;
  assign es_ready_go = !is_div || (div_state == DIV_DONE);
  assign es_allowin  = !es_valid || (es_ready_go && io.ms_allowin);

  // ---------------------------------------------------------------- pipeline
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= io.ds_to_es_valid;
    end
  end

  // NOTE: the payload is deliberately not reset; es_valid qualifies it, and
  // leaving it unreset keeps the wide register free of reset fan-out.
  always_ff @(posedge clk) begin
    if (io.ds_to_es_valid && es_allowin) begin
      es_bus <= io.ds_to_es_bus;
    end
  end

  // --------------------------------------------------------------------- ALU
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] alu_out;

  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;

  // NOTE: alu_out gets a default before any conditional update, so no latch
  // is inferred and an all-zero alu_op yields zero.
  always_comb begin
    alu_out = '0;
    if (alu_op[0])  alu_out = alu_out | add_res;
    if (alu_op[1])  alu_out = alu_out | sub_res;
    if (alu_op[2])  alu_out = alu_out | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[3])  alu_out = alu_out | {31'd0, src1 < src2};
    if (alu_op[4])  alu_out = alu_out | (src1 & src2);
    if (alu_op[5])  alu_out = alu_out | ~(src1 | src2);
    if (alu_op[6])  alu_out = alu_out | (src1 | src2);
    if (alu_op[7])  alu_out = alu_out | (src1 ^ src2);
    if (alu_op[8])  alu_out = alu_out | (src1 << src2[4:0]);
    if (alu_op[9])  alu_out = alu_out | (src1 >> src2[4:0]);
    if (alu_op[10]) alu_out = alu_out | $unsigned($signed(src1) >>> src2[4:0]);
    if (alu_op[11]) alu_out = alu_out | src2;
  end

  // ----------------------------------------------------------------- divider
  logic        div_signed;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        div_start;

  assign div_signed = div_op[0] | div_op[1];
  assign src1_neg   = div_signed & src1[31];
  assign src2_neg   = div_signed & src2[31];
  assign abs1       = src1_neg ? (32'd0 - src1) : src1;
  assign abs2       = src2_neg ? (32'd0 - src2) : src2;
  assign div_start  = (div_state == DIV_IDLE) && es_valid && is_div;

  logic [4:0]  div_cnt;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] div_dvs;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  // The dividend shifts out of div_quo while quotient bits shift in behind it.
  assign rem_shift = {div_rem, div_quo[31]};
  assign rem_diff  = rem_shift - {1'b0, div_dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (div_start) begin
            div_state <= DIV_BUSY;
            div_cnt   <= 5'd0;
          end
        end
        DIV_BUSY: begin
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) div_state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (io.ms_allowin) div_state <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (div_start) begin
      div_quo <= abs1;
      div_rem <= 32'd0;
      div_dvs <= abs2;
      q_neg   <= src1_neg ^ src2_neg;
      r_neg   <= src1_neg;
    end else if (div_state == DIV_BUSY) begin
      if (!rem_diff[32]) begin
        div_rem <= rem_diff[31:0];
        div_quo <= {div_quo[30:0], 1'b1};
      end else begin
        div_rem <= rem_shift[31:0];
        div_quo <= {div_quo[30:0], 1'b0};
      end
    end
  end

  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_result;

  // Divide-by-zero is pinned to all-ones / dividend for every variant.
  always_comb begin
    quo_fix = q_neg ? (32'd0 - div_quo) : div_quo;
    rem_fix = r_neg ? (32'd0 - div_rem) : div_rem;
    if (div_dvs == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = src1;
    end
  end

  assign div_result = (div_op[0] | div_op[2]) ? quo_fix : rem_fix;
  assign alu_result = is_div ? div_result : alu_out;

  // ----------------------------------------------------------------- outputs
  logic sram_en;
  logic blocked;

  assign sram_en = es_valid && es_ready_go && io.ms_allowin
                   && (res_from_mem || mem_we);
  assign blocked = es_valid && (res_from_mem || !es_ready_go);

  assign io.es_allowin      = es_allowin;
  assign io.es_to_ms_valid  = es_valid && es_ready_go;
  assign io.es_to_ms_bus    = {res_from_mem, gr_we, dest, alu_result, pc};
  assign io.data_sram_en    = sram_en;
  assign io.data_sram_we    = {4{sram_en && mem_we}};
  assign io.data_sram_addr  = alu_result;
  assign io.data_sram_wdata = rkd_value;
  assign io.out_es_valid    = es_valid;
  assign io.es_fwd_bus      = {es_valid && gr_we, blocked, dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: a scoreboard of expected EXE->MEM
// handoffs (bus + SRAM request) plus per-scenario cycle and signal checks.
module tb_exe_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exe_stage_if io();
  exe_stage dut (.clk(clk), .reset(reset), .io(io));

  typedef struct packed {
    logic [11:0] aop;
    logic [3:0]  dop;
    logic        rfm;
    logic        mw;
    logic        gw;
    logic [4:0]  dest;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rkd;
    logic [31:0] pc;
  } inst_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [70:0] bus;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t got_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int sram_cnt = 0;
  int stray_sram = 0;

  // Monitor: capture every handoff, and any SRAM request outside one.
  always @(negedge clk) begin
    if (!reset && io.es_to_ms_valid && io.ms_allowin)
      got_q.push_back({io.data_sram_en, io.data_sram_we, io.data_sram_addr,
                       io.data_sram_wdata, io.es_to_ms_bus});
    if (io.data_sram_en) begin
      sram_cnt++;
      if (!(io.es_to_ms_valid && io.ms_allowin)) stray_sram++;
    end
  end

  // ------------------------------------------------------------------ model
  function automatic logic [31:0] alu_model(input logic [11:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return $unsigned($signed(a) >>> b[4:0]);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_model(input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return (op[0] | op[2]) ? 32'hFFFF_FFFF : a;
    if (op[0]) return ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b));
    if (op[1]) return ovf ? 32'd0 : $unsigned($signed(a) % $signed(b));
    if (op[2]) return a / b;
    return a % b;
  endfunction

  function automatic xfer_t expect_of(input inst_t i);
    logic [31:0] r;
    r = (i.dop != 4'd0) ? div_model(i.dop, i.s1, i.s2) : alu_model(i.aop, i.s1, i.s2);
    return {i.rfm | i.mw, {4{i.mw}}, r, i.rkd, {i.rfm, i.gw, i.dest, r, i.pc}};
  endfunction

  function automatic inst_t mk(input logic [11:0] aop, input logic [3:0] dop,
                               input logic rfm, input logic mw, input logic gw,
                               input logic [4:0] dest, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [31:0] rkd,
                               input logic [31:0] pc);
    return {aop, dop, rfm, mw, gw, dest, s1, s2, rkd, pc};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns #1 after the edge that loaded it.
  task automatic issue(input inst_t i, input bit push);
    int n;
    if (push) exp_q.push_back(expect_of(i));
    io.ds_to_es_valid = 1'b1;
    io.ds_to_es_bus   = i;
    n = 0;
    while (!io.es_allowin && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: es_allowin stayed 0 for %0d cycles, needed 1", n);
    end
    tick();
    io.ds_to_es_valid = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b1;
    io.ms_allowin = 1'b1;
    io.ds_to_es_valid = 1'b0;
    io.ds_to_es_bus = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (io.out_es_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_es_valid: got %b want 0", io.out_es_valid); end
    n_checks++;
    if (io.es_to_ms_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_to_ms_valid: got %b want 0", io.es_to_ms_valid); end
    n_checks++;
    if ({io.data_sram_en, io.data_sram_we} !== 5'b0) begin n_fail++;
      $display("FAIL reset_sram: got en=%b we=%h want 0/0", io.data_sram_en, io.data_sram_we); end
    n_checks++;
    if (io.es_fwd_bus[38] !== 1'b0) begin n_fail++;
      $display("FAIL reset_fwd_we: got %b want 0", io.es_fwd_bus[38]); end
    n_checks++;
    if (io.es_allowin !== 1'b1) begin n_fail++;
      $display("FAIL reset_allowin: got %b want 1", io.es_allowin); end
  endtask

  task automatic test_alu();
    logic [11:0] ops [13];
    xfer_t e, g;
    int n;
    issue(mk(12'h001, 4'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'h1C00_0000), 1'b1);
    n_checks++;
    if (io.es_to_ms_valid !== 1'b1 || io.es_to_ms_bus[63:32] !== 32'd2 ||
        io.es_to_ms_bus[68:64] !== 5'd3) begin n_fail++;
      $display("FAIL alu_add_first: got v=%b res=%h dest=%0d want 1/00000002/3",
               io.es_to_ms_valid, io.es_to_ms_bus[63:32], io.es_to_ms_bus[68:64]); end
    n_checks++;
    if (io.data_sram_en !== 1'b0) begin n_fail++;
      $display("FAIL alu_add_sram: got en=%b want 0", io.data_sram_en); end
    n_checks++;
    if (io.es_fwd_bus !== {1'b1, 1'b0, 5'd3, 32'd2}) begin n_fail++;
      $display("FAIL alu_add_fwd: got %h want %h", io.es_fwd_bus, {1'b1, 1'b0, 5'd3, 32'd2}); end

    for (int k = 0; k < 12; k++) ops[k] = 12'h001 << k;
    ops[12] = 12'h000;
    for (int k = 0; k < 13; k++)
      issue(mk(ops[k], 4'd0, 1'b0, 1'b0, 1'b1, 5'(k + 1), 32'h8765_4321,
               32'h0000_0F13, 32'd0, 32'h1C00_0100 + 32'(k * 4)), 1'b1);

    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++;
        $display("FAIL alu_handoff: got no handoff, want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++;
          $display("FAIL alu_handoff: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_store();
    xfer_t e, g;
    int c, n;
    issue(mk(12'h001, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_1000, 32'd4,
             32'hDEAD_BEEF, 32'h1C00_0200), 1'b1);
    c = sram_cnt;
    n_checks++;
    if ({io.data_sram_en, io.data_sram_we, io.data_sram_addr, io.data_sram_wdata} !==
        {1'b1, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL store_req: got en=%b we=%h addr=%h wdata=%h want 1/f/00001004/deadbeef",
               io.data_sram_en, io.data_sram_we, io.data_sram_addr, io.data_sram_wdata); end
    tick();
    n_checks++;
    if (io.data_sram_en !== 1'b0) begin n_fail++;
      $display("FAIL store_single: en in next cycle got %b want 0", io.data_sram_en); end
    tick();
    n_checks++;
    if (sram_cnt !== c + 1) begin n_fail++;
      $display("FAIL store_count: got %0d requests want 1", sram_cnt - c); end
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++;
        $display("FAIL store_handoff: got no handoff, want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++;
          $display("FAIL store_handoff: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_div();
    logic [3:0]  dop [9];
    logic [31:0] da  [9];
    logic [31:0] db  [9];
    xfer_t e, g;
    int n;
    dop[0] = 4'b0001; da[0] = 32'hFFFF_FFF9; db[0] = 32'd2;
    dop[1] = 4'b0010; da[1] = 32'hFFFF_FFF9; db[1] = 32'd2;
    dop[2] = 4'b0100; da[2] = 32'hFFFF_FFF9; db[2] = 32'd2;
    dop[3] = 4'b0001; da[3] = 32'h1234_5678; db[3] = 32'd0;
    dop[4] = 4'b1000; da[4] = 32'd9;         db[4] = 32'd0;
    dop[5] = 4'b0001; da[5] = 32'h8000_0000; db[5] = 32'hFFFF_FFFF;
    dop[6] = 4'b0010; da[6] = 32'h8000_0000; db[6] = 32'hFFFF_FFFF;
    dop[7] = 4'b0010; da[7] = 32'd7;         db[7] = 32'hFFFF_FFFE;
    dop[8] = 4'b0010; da[8] = 32'hFFFF_FFF9; db[8] = 32'd0;
    for (int k = 0; k < 9; k++) begin
      issue(mk(12'h001, dop[k], 1'b0, 1'b0, 1'b1, 5'd9, da[k], db[k], 32'd0,
               32'h1C00_0300 + 32'(k * 4)), 1'b1);
      if (k == 0) begin
        n_checks++;
        if (io.es_fwd_bus[37] !== 1'b1 || io.es_to_ms_valid !== 1'b0) begin n_fail++;
          $display("FAIL div_busy_blocked: got blocked=%b to_ms_valid=%b want 1/0",
                   io.es_fwd_bus[37], io.es_to_ms_valid); end
      end
      n = 0;
      while (!io.es_allowin && n < 100) begin n++; tick(); end
      n_checks++;
      if (n != 33) begin n_fail++;
        $display("FAIL div_latency[%0d]: got %0d stall cycles want 33", k, n); end
    end
    tick();
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++;
        $display("FAIL div_handoff: got no handoff, want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++;
          $display("FAIL div_handoff: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_mem_stall();
    inst_t add_i;
    xfer_t e, g;
    int n;
    io.ms_allowin = 1'b0;
    issue(mk(12'h000, 4'b0100, 1'b0, 1'b0, 1'b1, 5'd12, 32'd100, 32'd7, 32'd0,
             32'h1C00_0400), 1'b1);
    n = 0;
    while (!io.es_to_ms_valid && n < 100) begin n++; tick(); end
    n_checks++;
    if (n != 33) begin n_fail++;
      $display("FAIL stall_latency: got %0d cycles want 33", n); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (io.es_to_ms_valid !== 1'b1 || io.es_to_ms_bus !== exp_q[0].bus ||
          io.data_sram_en !== 1'b0 || io.es_allowin !== 1'b0) begin n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b bus=%h en=%b allowin=%b want 1/%h/0/0",
                 k, io.es_to_ms_valid, io.es_to_ms_bus, io.data_sram_en,
                 io.es_allowin, exp_q[0].bus); end
      tick();
    end
    add_i = mk(12'h001, 4'd0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_0010,
               32'h0000_0020, 32'd0, 32'h1C00_0404);
    exp_q.push_back(expect_of(add_i));
    io.ds_to_es_valid = 1'b1;
    io.ds_to_es_bus   = add_i;
    io.ms_allowin     = 1'b1;
    #1;
    n_checks++;
    if (io.es_allowin !== 1'b1) begin n_fail++;
      $display("FAIL stall_release_allowin: got %b want 1", io.es_allowin); end
    tick();
    io.ds_to_es_valid = 1'b0;
    n_checks++;
    if (io.es_to_ms_valid !== 1'b1 || io.es_to_ms_bus[63:32] !== 32'h0000_0030) begin n_fail++;
      $display("FAIL back_to_back_add: got v=%b res=%h want 1/00000030",
               io.es_to_ms_valid, io.es_to_ms_bus[63:32]); end
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++;
        $display("FAIL stall_handoff: got no handoff, want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++;
          $display("FAIL stall_handoff: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    xfer_t e, g;
    int c_sram, c_got, n;
    // Discarded divide carries res_from_mem so a wrong handoff would hit SRAM.
    issue(mk(12'h000, 4'b0001, 1'b1, 1'b0, 1'b1, 5'd20, 32'd100, 32'd3, 32'd0,
             32'h1C00_0500), 1'b0);
    c_sram = sram_cnt;
    c_got  = got_q.size();
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (io.out_es_valid !== 1'b0 || io.es_to_ms_valid !== 1'b0 || io.es_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_div_reset: got es_valid=%b to_ms=%b allowin=%b want 0/0/1",
               io.out_es_valid, io.es_to_ms_valid, io.es_allowin); end
    repeat (40) tick();
    n_checks++;
    if (sram_cnt !== c_sram || got_q.size() !== c_got) begin n_fail++;
      $display("FAIL mid_div_discard: got %0d sram reqs, %0d handoffs want 0/0",
               sram_cnt - c_sram, got_q.size() - c_got); end
    issue(mk(12'h000, 4'b0010, 1'b0, 1'b0, 1'b1, 5'd21, 32'hFFFF_FFF9, 32'd2, 32'd0,
             32'h1C00_0504), 1'b1);
    n = 0;
    while (!io.es_allowin && n < 100) begin n++; tick(); end
    n_checks++;
    if (n != 33) begin n_fail++;
      $display("FAIL post_reset_latency: got %0d stall cycles want 33", n); end
    tick();
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++;
        $display("FAIL post_reset_handoff: got no handoff, want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++;
          $display("FAIL post_reset_handoff: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_load_blocked();
    int n;
    io.ms_allowin = 1'b0;
    issue(mk(12'h001, 4'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_2000, 32'd8, 32'd0,
             32'h1C00_0600), 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (io.es_fwd_bus !== {1'b1, 1'b1, 5'd7, 32'h0000_2008} || io.data_sram_en !== 1'b0) begin
        n_fail++;
        $display("FAIL load_blocked[%0d]: got fwd=%h en=%b want %h/0", k, io.es_fwd_bus,
                 io.data_sram_en, {1'b1, 1'b1, 5'd7, 32'h0000_2008}); end
      tick();
    end
    io.ms_allowin = 1'b1;
    #1;
    n_checks++;
    if ({io.data_sram_en, io.data_sram_we, io.data_sram_addr} !== {1'b1, 4'h0, 32'h0000_2008}) begin
      n_fail++;
      $display("FAIL load_req: got en=%b we=%h addr=%h want 1/0/00002008",
               io.data_sram_en, io.data_sram_we, io.data_sram_addr); end
    tick();
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin tick(); n++; end
    n_checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin n_fail++;
      $display("FAIL load_handoff: got %0d handoffs want 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin n_fail++;
      $display("FAIL load_handoff: got %h want %h", got_q[0], exp_q[0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_div();
    test_mem_stall();
    test_reset_mid_div();
    test_load_blocked();
    repeat (3) tick();
    n_checks++;
    if (stray_sram != 0) begin n_fail++;
      $display("FAIL stray_sram: got %0d requests outside handoff want 0", stray_sram); end
    n_checks++;
    if (got_q.size() != 0) begin n_fail++;
      $display("FAIL extra_handoffs: got %0d unexpected want 0", got_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
